// File: rtl/mc_luma_pred_buf_pkg.sv
// Shared encoder defines for the MC luma prediction buffer: pixel width and
// the MB-relative origin mapping of 8x4 write regions and 4x4 read blocks.
package mc_luma_pred_buf_pkg;

  localparam int BIT_DEPTH  = 8;
  localparam int MB_PIX     = 256;
  localparam int REGION_W   = 32 * BIT_DEPTH;
  localparam int BLK_W      = 16 * BIT_DEPTH;

  // Region a: x = a[1]*8, y = {a[2],a[0]}*4
  function automatic logic [3:0] region_x0(input logic [2:0] a);
    return {a[1], 3'b000};
  endfunction

  function automatic logic [3:0] region_y0(input logic [2:0] a);
    return {a[2], a[0], 2'b00};
  endfunction

  // Block b: 8x8 quadrant order, raster inside each quadrant
  function automatic logic [3:0] blk_x0(input logic [3:0] b);
    return {b[2], b[0], 2'b00};
  endfunction

  function automatic logic [3:0] blk_y0(input logic [3:0] b);
    return {b[3], b[1], 2'b00};
  endfunction

endpackage

// File: rtl/mc_luma_pred_buf_if.sv
// Write port from the MC luma stage and the 4x4 prediction handshake.
interface mc_luma_pred_buf_if;
  import mc_luma_pred_buf_pkg::*;

  logic                 luma_wren_i;
  logic [2:0]           luma_wraddr_i;
  logic [REGION_W-1:0]  luma_wrdata_i;
  logic                 pred_full_o;
  logic                 pred_valid_o;
  logic                 pred_ready_i;
  logic [3:0]           pred_blk_idx_o;
  logic [BLK_W-1:0]     pred_data_o;
  logic                 overflow_o;

  modport master (
    output luma_wren_i, luma_wraddr_i, luma_wrdata_i, pred_ready_i,
    input  pred_full_o, pred_valid_o, pred_blk_idx_o, pred_data_o, overflow_o
  );

  modport slave (
    input  luma_wren_i, luma_wraddr_i, luma_wrdata_i, pred_ready_i,
    output pred_full_o, pred_valid_o, pred_blk_idx_o, pred_data_o, overflow_o
  );

endinterface

// File: rtl/mc_luma_pred_bank.sv
// One 16x16 luma MB store: 8x4 region write port, combinational 4x4 block read.
module mc_luma_pred_bank
  import mc_luma_pred_buf_pkg::*;
(
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [2:0]          waddr_i,
  input  logic [REGION_W-1:0] wdata_i,
  input  logic [3:0]          ridx_i,
  output logic [BLK_W-1:0]    rdata_o
);

  // Pixel (x,y) lives at {y,x}; no reset, contents are qualified by the full flags
  logic [BIT_DEPTH-1:0] mem [MB_PIX];

  logic [3:0] wx, wy, rx, ry;
  assign wx = region_x0(waddr_i);
  assign wy = region_y0(waddr_i);
  assign rx = blk_x0(ridx_i);
  assign ry = blk_y0(ridx_i);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 8; i++) begin
          mem[{wy + 4'(k), wx + 4'(i)}] <= wdata_i[(k*8+i)*BIT_DEPTH +: BIT_DEPTH];
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rdata_o[(4*r+c)*BIT_DEPTH +: BIT_DEPTH] = mem[{ry + 4'(r), rx + 4'(c)}];
      end
    end
  end

endmodule

// File: rtl/mc_luma_pred_buf.sv
// Ping-pong luma prediction buffer: collects eight 8x4 regions per MB and
// streams the MB out as sixteen 4x4 blocks, one per cycle.
module mc_luma_pred_buf
  import mc_luma_pred_buf_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  mc_luma_pred_buf_if.slave bus
);

  logic                   wbank, rbank;
  logic [1:0]             full;
  logic [2:0]             wcnt;
  logic [3:0]             ridx;
  logic                   ovf;
  logic [1:0][BLK_W-1:0]  rdata;

  logic wr_acc, wr_last, xfer, rd_last;
  assign wr_acc  = bus.luma_wren_i & ~full[wbank];
  assign wr_last = wr_acc & (wcnt == 3'd7);
  assign xfer    = full[rbank] & bus.pred_ready_i;
  assign rd_last = xfer & (ridx == 4'd15);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mc_luma_pred_bank u_bank (
      .clk_i   (clk_i),
      .we_i    (wr_acc && (wbank == 1'(g))),
      .waddr_i (bus.luma_wraddr_i),
      .wdata_i (bus.luma_wrdata_i),
      .ridx_i  (ridx),
      .rdata_o (rdata[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
      wcnt  <= '0;
      ridx  <= '0;
      ovf   <= 1'b0;
    end else begin
      // wcnt and ridx wrap to zero on their last increment
      if (wr_acc)  wcnt  <= wcnt + 3'd1;
      if (wr_last) wbank <= ~wbank;
      if (xfer)    ridx  <= ridx + 4'd1;
      if (rd_last) rbank <= ~rbank;
      if (bus.luma_wren_i && full[wbank]) ovf <= 1'b1;
      // set and clear never hit the same bank: wbank != rbank while rbank is full
      for (int g = 0; g < 2; g++) begin
        if (wr_last && (wbank == 1'(g)))      full[g] <= 1'b1;
        else if (rd_last && (rbank == 1'(g))) full[g] <= 1'b0;
      end
    end
  end

  assign bus.pred_valid_o   = full[rbank];
  assign bus.pred_full_o    = &full;
  assign bus.pred_blk_idx_o = ridx;
  assign bus.pred_data_o    = rdata[rbank];
  assign bus.overflow_o     = ovf;

endmodule

// File: doc/mc_luma_pred_buf.md
MC_LUMA_PRED_BUF -- requirements
Module: mc_luma_pred_buf

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_i input 1 (clock, rising edge) and rst_i input 1 (reset).
REQ-002 BIT_DEPTH, default 8, SHALL set the pixel width in bits and SHALL come from the shared encoder defines.
REQ-003 The block SHALL have port luma_wren_i, input, 1 bit: write strobe from the MC luma stage.
REQ-004 The block SHALL have port luma_wraddr_i, input, 3 bits: 8x4 region address.
REQ-005 The block SHALL have port luma_wrdata_i, input, 32*BIT_DEPTH bits: 4 rows x 8 pixels.
REQ-006 The block SHALL have port pred_full_o, output, 1 bit: both banks are occupied, so upstream SHALL NOT launch the next MB.
REQ-007 The block SHALL have port pred_valid_o, output, 1 bit: a 4x4 block is available.
REQ-008 The block SHALL have port pred_ready_i, input, 1 bit: the downstream stage accepts the block.
REQ-009 The block SHALL have port pred_blk_idx_o, output, 4 bits: 4x4 block index, 0..15.
REQ-010 The block SHALL have port pred_data_o, output, 16*BIT_DEPTH bits: 4x4 prediction block.
REQ-011 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a write is dropped.

Function
REQ-012 Input packing SHALL be: row k of a region at luma_wrdata_i[k*8*BIT_DEPTH +: 8*BIT_DEPTH]; pixel i of that row at [i*BIT_DEPTH +: BIT_DEPTH]; pixel 0 is leftmost.
REQ-013 Region address a SHALL map to MB origin x = a[1]*8, y = {a[2],a[0]}*4; addresses arrive in any order.
REQ-014 Storage SHALL be two banks (ping-pong) of 256 pixels each, with a write pointer wbank, a read pointer rbank, and a full flag per bank.
REQ-015 Each write strobe into a non-full wbank SHALL store 32 pixels and increment a 3-bit write count.
REQ-016 The 8th write SHALL set full[wbank], toggle wbank, and clear the write count.
REQ-017 A write strobe while full[wbank]=1 SHALL be dropped and SHALL set overflow_o, which holds until reset.
REQ-018 pred_valid_o SHALL equal full[rbank] and SHALL first assert the cycle after the 8th write's clock edge.
REQ-019 Block index b SHALL map to origin x = b[2]*8 + b[0]*4, y = b[3]*8 + b[1]*4 (8x8 quadrant order, raster inside each quadrant).
REQ-020 pred_data_o pixel (r,c) SHALL be at [(4r+c)*BIT_DEPTH +: BIT_DEPTH], driven combinationally from rbank at the current read index.
REQ-021 A transfer SHALL occur when pred_valid_o=1 and pred_ready_i=1; each transfer SHALL advance the read index by 1.
REQ-022 The transfer of block 15 SHALL clear full[rbank], toggle rbank, and wrap the read index to 0.
REQ-023 While pred_valid_o=1 and pred_ready_i=0, pred_data_o and pred_blk_idx_o SHALL hold stable.
REQ-024 When a bank's 8th write and another bank's final read occur in the same cycle, both updates SHALL take effect.
REQ-025 pred_full_o SHALL equal full[0] & full[1].
REQ-026 A write into the bank being freed in the same cycle cannot occur by construction (wbank != rbank whenever rbank is full); no extra logic SHALL be added for it.
REQ-027 Throughput SHALL be one 4x4 block per cycle, i.e. a full MB drained in 16 cycles with ready held high.

Reset
REQ-028 With rst_i=1 at a clock edge, the block SHALL clear wbank, rbank, both full flags, the write count, the read index and overflow_o.
REQ-029 After reset, pred_valid_o=0, pred_full_o=0, pred_blk_idx_o=0 and overflow_o=0; pred_data_o is don't-care while invalid.
REQ-030 Reset asserted mid-MB SHALL discard all partial and complete MBs; pixel storage need not be cleared.

Structure
REQ-031 BIT_DEPTH and the region/block origin mapping constants SHALL live in the shared encoder defines; no new package is needed.
REQ-032 One sub-module, mc_luma_pred_bank, SHALL be used: a 256-pixel store with an 8x4 region write port and a 4x4 block read port, instantiated twice.
REQ-033 The top level SHALL hold the pointers, counters, full flags and handshake logic.

Verification
REQ-034 Reset, then write addresses 0..7 with pixel value = x+16y -> pred_valid_o rises one cycle later; with ready=1, blocks 0..15 appear in 16 consecutive cycles; block 3 pixel (0,0) = 0x44.
REQ-035 Write addresses in the order 0,1,4,5,2,3,6,7 -> output identical to REQ-034.
REQ-036 Write two MBs back to back with ready=0 -> pred_full_o=1 after the 16th write; a 17th write -> overflow_o=1 and bank contents unchanged.
REQ-037 Ready toggled 1,0,1,0 -> each index is presented until accepted; no index is skipped or repeated.
REQ-038 The 8th write of MB1 coincides with the block-15 transfer of MB0 -> MB1 is valid on the next cycle at index 0; pred_full_o stays 0.
REQ-039 rst_i asserted after 5 writes -> outputs return to reset values; a fresh 8-write MB is then read correctly.
